// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared opcodes, host command fill values and dispatcher state encoding
package accel_pkg;

   // Opcodes: value k selects engine k-1
   localparam int MULTIPLICATION_OPERATION = 1;
   localparam int CONVOLUTION_OPERATION    = 2;

   // Host command words are a single bit replicated across the status width
   localparam bit STATUS_START = 1'b1;   // all-ones: launch
   localparam bit STATUS_CLEAR = 1'b0;   // all-zeros: acknowledge / clear

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } dispatch_state_e;

endpackage

// File: rtl/dispatch_latency_counter.sv
// rtl/dispatch_latency_counter.sv - saturating run-cycle counter with clear, enable and limit compare
module dispatch_latency_counter #(
   parameter int CNT_WIDTH = 24,
   parameter int LIMIT     = 0     // 0 disables the limit compare
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_clear,
   input  logic                 i_enable,
   output logic [CNT_WIDTH-1:0] o_count,
   output logic                 o_at_limit
);

   logic [CNT_WIDTH-1:0] r_count;

   // Count enabled cycles, holding at all-ones instead of wrapping
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != '1)) begin
         r_count <= r_count + CNT_WIDTH'(1);
      end
   end

   // High when the next counted cycle is the LIMIT-th one
   assign o_at_limit = (LIMIT > 0) && (r_count >= CNT_WIDTH'(LIMIT - 1));
   assign o_count    = r_count;

endmodule

// File: rtl/accel_dispatch_unit.sv
// rtl/accel_dispatch_unit.sv - launches one accelerator per host start; optional watchdog via DISPATCH_WATCHDOG_EN
module accel_dispatch_unit
   import accel_pkg::*;
#(
   parameter int NUM_ENGINES    = 2,
   parameter int OP_WIDTH       = 32,
   parameter int STATUS_WIDTH   = 32,
   parameter int CNT_WIDTH      = 24,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [STATUS_WIDTH-1:0] status,
   input  logic [OP_WIDTH-1:0]     operation,
   input  logic [NUM_ENGINES-1:0]  engine_done,
   output logic [NUM_ENGINES-1:0]  engine_enable,
   output logic                    busy,
   output logic                    finished,
   output logic                    error,
   output logic                    error_timeout,
   output logic [CNT_WIDTH-1:0]    cycle_count
);

`ifdef DISPATCH_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif
   // Without the watchdog the counter never reports a limit, so expiry is constant 0
   localparam int WD_LIMIT = WD_EN ? TIMEOUT_CYCLES : 0;

   dispatch_state_e        r_state;
   logic [NUM_ENGINES-1:0] r_enable;
   logic                   r_busy;
   logic                   r_finished;
   logic                   r_error;
   logic                   r_error_timeout;

   logic                   w_start;
   logic                   w_clear;
   logic                   w_op_valid;
   logic [OP_WIDTH-1:0]    w_op_m1;
   logic [NUM_ENGINES-1:0] w_onehot;
   logic                   w_sel_done;
   logic                   w_launch;
   logic                   w_expire;

   assign w_start    = (status == {STATUS_WIDTH{STATUS_START}});
   assign w_clear    = (status == {STATUS_WIDTH{STATUS_CLEAR}});
   assign w_op_valid = (operation >= OP_WIDTH'(MULTIPLICATION_OPERATION)) &&
                       (operation <= OP_WIDTH'(NUM_ENGINES));
   assign w_op_m1    = operation - OP_WIDTH'(1);
   assign w_onehot   = NUM_ENGINES'(1) << w_op_m1;
   // The latched enable mask doubles as the done selector: only the running engine is heard
   assign w_sel_done = |(engine_done & r_enable);
   assign w_launch   = (r_state == ST_IDLE) && w_start && w_op_valid;

   dispatch_latency_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .LIMIT     (WD_LIMIT)
   ) u_latency (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_clear    (w_launch),
      .i_enable   (r_state == ST_RUN),
      .o_count    (cycle_count),
      .o_at_limit (w_expire)
   );

   // Dispatcher FSM with registered outputs; done takes priority over watchdog expiry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state         <= ST_IDLE;
         r_enable        <= '0;
         r_busy          <= 1'b0;
         r_finished      <= 1'b0;
         r_error         <= 1'b0;
         r_error_timeout <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  if (w_op_valid) begin
                     r_state  <= ST_RUN;
                     r_enable <= w_onehot;
                     r_busy   <= 1'b1;
                  end else begin
                     r_state         <= ST_ERR;
                     r_error         <= 1'b1;
                     r_error_timeout <= 1'b0;
                  end
               end
            end
            ST_RUN: begin
               if (w_sel_done) begin
                  r_state    <= ST_DONE;
                  r_enable   <= '0;
                  r_busy     <= 1'b0;
                  r_finished <= 1'b1;
               end else if (w_expire) begin
                  r_state         <= ST_ERR;
                  r_enable        <= '0;
                  r_busy          <= 1'b0;
                  r_error         <= 1'b1;
                  r_error_timeout <= 1'b1;
               end
            end
            ST_DONE: begin
               if (w_clear) begin
                  r_state    <= ST_IDLE;
                  r_finished <= 1'b0;
               end
            end
            ST_ERR: begin
               if (w_clear) begin
                  r_state         <= ST_IDLE;
                  r_error         <= 1'b0;
                  r_error_timeout <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign engine_enable = r_enable;
   assign busy          = r_busy;
   assign finished      = r_finished;
   assign error         = r_error;
   assign error_timeout = r_error_timeout;

endmodule
